// File: rtl/maze_ram_if.sv
// Controller and video port bundle for the maze tile store.
interface maze_ram_if;
   logic       init_start;
   logic       init_done;
   logic [9:0] ctrl_raddr;
   logic [3:0] ctrl_rdata;
   logic [9:0] ctrl_waddr;
   logic [3:0] ctrl_wdata;
   logic       ctrl_we;
   logic [9:0] vid_raddr;
   logic [3:0] vid_rdata;

   modport master (
      output init_start, ctrl_raddr, ctrl_waddr, ctrl_wdata, ctrl_we, vid_raddr,
      input  init_done, ctrl_rdata, vid_rdata
   );

   modport slave (
      input  init_start, ctrl_raddr, ctrl_waddr, ctrl_wdata, ctrl_we, vid_raddr,
      output init_done, ctrl_rdata, vid_rdata
   );
endinterface

// File: rtl/maze_ram.sv
// Labyrinth tile store: 1024x4 RAM with controller R/W port, video read port
// and a self-initialising arena layout writer.
module maze_ram #(
   parameter int unsigned COLS       = 25,
   parameter int unsigned ROWS       = 17,
   parameter logic [3:0]  TILE_EMPTY = 4'h0,
   parameter logic [3:0]  TILE_WALL  = 4'h1,
   parameter logic [3:0]  TILE_BLOCK = 4'h2,
   parameter logic [3:0]  TILE_OUT   = 4'hF
) (
   input  logic        clk,
   input  logic        reset_n,
   maze_ram_if.slave   bus
);
   localparam int unsigned AW    = 10;
   localparam int unsigned DW    = 4;
   localparam int unsigned DEPTH = 1 << AW;

   localparam logic [4:0]    COL_LIM  = 5'(COLS);
   localparam logic [4:0]    ROW_LIM  = 5'(ROWS);
   localparam logic [4:0]    COL_LAST = 5'(COLS - 1);
   localparam logic [4:0]    ROW_LAST = 5'(ROWS - 1);
   localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

   typedef enum logic {INIT, RUN} state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   init_cnt, cnt_nxt;
   logic            done_nxt;
   logic            we_c;
   logic [AW-1:0]   waddr_c;
   logic [DW-1:0]   wdata_c;
   logic [DW-1:0]   mem [DEPTH];

   // Arena layout for one address {row,col}
   function automatic logic [DW-1:0] tile(input logic [AW-1:0] a);
      logic [4:0] row;
      logic [4:0] col;
      row = a[9:5];
      col = a[4:0];
      if (col >= COL_LIM || row >= ROW_LIM)
         tile = TILE_OUT;
      else if (col == 5'd0 || col == COL_LAST || row == 5'd0 || row == ROW_LAST)
         tile = TILE_WALL;
      else if (!col[0] && !row[0])
         tile = TILE_BLOCK;
      else
         tile = TILE_EMPTY;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= INIT;
         init_cnt       <= '0;
         bus.init_done  <= 1'b0;
         bus.ctrl_rdata <= '0;
         bus.vid_rdata  <= '0;
      end else begin
         state          <= state_nxt;
         init_cnt       <= cnt_nxt;
         bus.init_done  <= done_nxt;
         bus.ctrl_rdata <= mem[bus.ctrl_raddr];
         bus.vid_rdata  <= mem[bus.vid_raddr];
      end
   end

   // Array is never cleared; a write landing in a reset cycle is dropped
   always_ff @(posedge clk) begin
      if (reset_n && we_c)
         mem[waddr_c] <= wdata_c;
   end

   // Next state, init counter and single write-port mux
   always_comb begin
      state_nxt = state;
      cnt_nxt   = init_cnt;
      done_nxt  = bus.init_done;
      we_c      = 1'b0;
      waddr_c   = bus.ctrl_waddr;
      wdata_c   = bus.ctrl_wdata;
      case (state)
         INIT: begin
            we_c    = 1'b1;
            waddr_c = init_cnt;
            wdata_c = tile(init_cnt);
            cnt_nxt = AW'(init_cnt + AW'(1));
            if (init_cnt == CNT_LAST) begin
               state_nxt = RUN;
               done_nxt  = 1'b1;
            end
            if (bus.init_start) begin
               state_nxt = INIT;
               cnt_nxt   = '0;
               done_nxt  = 1'b0;
            end
         end
         RUN: begin
            if (bus.init_start) begin
               state_nxt = INIT;
               cnt_nxt   = '0;
               done_nxt  = 1'b0;
            end else if (bus.ctrl_we) begin
               we_c = 1'b1;
            end
         end
         default: state_nxt = INIT;
      endcase
   end
endmodule
